// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg
// Shared definitions for the instruction cache: default geometry, derived
// address-field widths, the instruction width seen by the pipeline, the
// refill FSM state encoding and a saturating-increment helper for the
// optional statistics counters (ICACHE_STATS_EN).
package instr_cache_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int INSTR_WIDTH        = 32;
    localparam int DEF_LINES          = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    localparam int OFFSET_BITS = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_BITS  = $clog2(DEF_LINES);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/instr_cache_if.sv
// instr_cache_if
// Refill bus between the instruction cache and the backing instruction
// memory.
//   mem_req   cache requests a beat at mem_addr
//   mem_addr  word-aligned beat address
//   mem_ack   memory accepts the beat; mem_data is valid in the same cycle
//   mem_data  beat data
// Modports: master = cache side, slave = memory side.
interface instr_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );

endinterface

// File: rtl/icache_line_store.sv
// icache_line_store
// Register storage for a direct-mapped cache: per line a valid bit, a tag and
// WORDS data words.
// Ports:
//   clk, rst                 clock, async active-high reset (clears valid only)
//   rd_index, rd_offset      combinational read address
//   rd_valid, rd_tag, rd_data combinational read results
//   wr_en, wr_index, wr_offset, wr_data   single-word write port
//   set_valid, set_tag       write tag of wr_index and mark it valid
//   flush_all                clear every valid bit (wins over set_valid)
module icache_line_store
    import instr_cache_pkg::*;
#(
    parameter int LINES    = DEF_LINES,
    parameter int WORDS    = DEF_WORDS_PER_LINE,
    parameter int DATA_W   = INSTR_WIDTH,
    parameter int OFFSET_W = OFFSET_BITS,
    parameter int INDEX_W  = INDEX_BITS,
    parameter int TAG_W    = TAG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                set_valid,
    input  logic [TAG_W-1:0]    set_tag,
    input  logic                flush_all
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only trusted once valid is set.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[wr_index] <= set_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/instr_cache.sv
// instr_cache
// Direct-mapped read-only instruction cache. Hits return the word in the same
// cycle; a miss stalls fetch while the whole line is refilled in order, one
// beat per mem_ack, over the refill bus.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid, addr_i         fetch request and byte address (bits [1:0] ignored)
//   flush_i                   invalidate all lines
//   data_o, stall_o           fetched word, hold-PC request
//   mem (instr_cache_if.master) refill bus to backing memory
//   hit_count, miss_count     saturating statistics, only when ICACHE_STATS_EN
//                             is defined
//
// state        | meaning
// ST_IDLE      | lookup on addr_i; miss stalls and captures the line base
// ST_REFILL    | request beats of the captured line, write each acked beat
// ST_FILL_DONE | line valid, one more stall cycle, then re-lookup in IDLE
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = INSTR_WIDTH,
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    instr_cache_if.master         mem
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int LINE_W = ADDR_WIDTH - 2 - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]  fill_line_q, fill_line_d;
    logic               pending_flush_q, pending_flush_d;

    logic [OFF_W-1:0]   addr_offset;
    logic [IDX_W-1:0]   addr_index;
    logic [TAG_W-1:0]   addr_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic               hit;
    logic               stall;
    logic               wr_en;
    logic               set_valid;
    logic               flush_all;
    logic               miss_start;
    logic               unused_addr_bits;

    assign addr_offset      = addr_i[2 +: OFF_W];
    assign addr_index       = addr_i[2 + OFF_W +: IDX_W];
    assign addr_tag         = addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign unused_addr_bits = ^addr_i[1:0];

    icache_line_store #(
        .LINES    (LINES),
        .WORDS    (WORDS_PER_LINE),
        .DATA_W   (DATA_WIDTH),
        .OFFSET_W (OFF_W),
        .INDEX_W  (IDX_W),
        .TAG_W    (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (addr_index),
        .rd_offset (addr_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (fill_line_q[IDX_W-1:0]),
        .wr_offset (beat_q),
        .wr_data   (mem.mem_data),
        .set_valid (set_valid),
        .set_tag   (fill_line_q[LINE_W-1 -: TAG_W]),
        .flush_all (flush_all)
    );

    // A flush in the same cycle turns a would-be hit into a miss.
    assign hit = req_valid && rd_valid && (rd_tag == addr_tag)
                 && (state_q == ST_IDLE) && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            fill_line_q     <= '0;
            pending_flush_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            fill_line_q     <= fill_line_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        fill_line_d     = fill_line_q;
        pending_flush_d = pending_flush_q;
        stall           = 1'b0;
        wr_en           = 1'b0;
        set_valid       = 1'b0;
        flush_all       = 1'b0;
        miss_start      = 1'b0;
        mem.mem_req     = 1'b0;
        mem.mem_addr    = '0;

        case (state_q)
            ST_IDLE: begin
                flush_all = flush_i;
                if (req_valid && !hit) begin
                    stall       = 1'b1;
                    miss_start  = 1'b1;
                    fill_line_d = addr_i[ADDR_WIDTH-1 : 2 + OFF_W];
                    beat_d      = '0;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall        = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = {fill_line_q, beat_q, 2'b00};
                // Deferred so in-flight beats complete into a consistent line.
                if (flush_i) begin
                    pending_flush_d = 1'b1;
                end
                if (mem.mem_ack) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        set_valid = 1'b1;
                        state_d   = ST_FILL_DONE;
                    end
                end
            end
            ST_FILL_DONE: begin
                stall           = 1'b1;
                flush_all       = pending_flush_q || flush_i;
                pending_flush_d = 1'b0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, not just after it.
    assign stall_o = stall && !rst;
    assign data_o  = (hit && !rst) ? rd_data : '0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= sat_inc(hit_count);
            end
            if (miss_start) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache
// Self-checking bench for instr_cache. A line-level model (which line address
// each index holds, refill progress by beats) predicts stall/data/mem_req/
// mem_addr every cycle; directed sequences pin the model with literal values,
// then a randomized phase runs against it. Statistics checks are compiled in
// when ICACHE_STATS_EN is defined.
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] addr_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stall_o;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instr_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    instr_cache dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .addr_i    (addr_i),
        .flush_i   (flush_i),
        .data_o    (data_o),
        .stall_o   (stall_o),
        .mem       (mem_bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- backing memory responder ----------------
    int gap = 0;
    initial begin
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_bus.mem_ack = 1'b0;
                gap = 0;
            end else if (mem_bus.mem_req) begin
                if (gap == 0) begin
                    mem_bus.mem_ack  = 1'b1;
                    mem_bus.mem_data = memw(mem_bus.mem_addr);
                    gap = $urandom_range(0, 2);
                end else begin
                    mem_bus.mem_ack = 1'b0;
                    gap--;
                end
            end else begin
                // Stray acks while idle must be ignored.
                mem_bus.mem_ack  = ($urandom_range(0, 7) == 0);
                mem_bus.mem_data = $urandom;
            end
        end
    end

    // ---------------- line-level model + per-cycle compare ----------------
    int          m_mode;            // 0 lookup, 1 refilling, 2 refill finished
    bit  [15:0]  m_valid;
    logic [27:0] m_line [16];
    logic [27:0] m_fill;
    int          m_beats;
    bit          m_pflush;
    logic [31:0] m_hits, m_misses;
    logic [31:0] ack_log [$];

    bit          e_hit;
    int          e_idx;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_stall", 32'(stall_o), 32'd0);
            check("reset_mem_req", 32'(mem_bus.mem_req), 32'd0);
            check("reset_mem_addr", mem_bus.mem_addr, 32'd0);
            check("reset_data", data_o, 32'd0);
            m_mode = 0; m_valid = '0; m_beats = 0; m_pflush = 0;
            m_hits = 0; m_misses = 0;
        end else begin
            e_idx = int'(addr_i[7:4]);
            e_hit = (m_mode == 0) && req_valid && m_valid[e_idx]
                    && (m_line[e_idx] == addr_i[31:4]) && !flush_i;
`ifdef ICACHE_STATS_EN
            check("hit_count", hit_count, m_hits);
            check("miss_count", miss_count, m_misses);
`endif
            if (m_mode == 0) begin
                check("stall", 32'(stall_o), 32'(req_valid && !e_hit));
                check("mem_req_idle", 32'(mem_bus.mem_req), 32'd0);
                if (e_hit) check("hit_data", data_o, memw(addr_i));
                else if (!req_valid) check("idle_data", data_o, 32'd0);
            end else if (m_mode == 1) begin
                check("stall_refill", 32'(stall_o), 32'd1);
                check("mem_req_refill", 32'(mem_bus.mem_req), 32'd1);
                check("mem_addr", mem_bus.mem_addr, {m_fill, 4'b0000} + 32'(4 * m_beats));
            end else begin
                check("stall_done", 32'(stall_o), 32'd1);
                check("mem_req_done", 32'(mem_bus.mem_req), 32'd0);
            end
            if (mem_bus.mem_req && mem_bus.mem_ack) ack_log.push_back(mem_bus.mem_addr);

            // advance model to the state after the coming edge
            if (m_mode == 0) begin
                if (flush_i) m_valid = '0;
                if (e_hit) m_hits++;
                if (req_valid && !e_hit) begin
                    m_mode = 1; m_fill = addr_i[31:4]; m_beats = 0; m_misses++;
                end
            end else if (m_mode == 1) begin
                if (flush_i) m_pflush = 1;
                if (mem_bus.mem_ack) begin
                    m_beats++;
                    if (m_beats == 4) begin
                        m_valid[m_fill[3:0]] = 1'b1;
                        m_line[m_fill[3:0]]  = m_fill;
                        m_mode = 2;
                    end
                end
            end else begin
                if (m_pflush || flush_i) m_valid = '0;
                m_pflush = 0;
                m_mode = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int cycles);
        req_valid = 1'b1;
        addr_i    = a;
        cycles    = 0;
        d         = '0;
        forever begin
            @(negedge clk);
            if (!stall_o) begin
                d = data_o;
                break;
            end
            cycles++;
            if (cycles > 200) begin
                check("fetch_timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target);
        for (int k = 0; k < 100 && ack_log.size() < target; k++) @(posedge clk);
        check("ack_wait", 32'(ack_log.size() >= target), 32'd1);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t;
        int tv;
        tv = $urandom_range(0, 4);
        t  = (tv == 4) ? 32'hFFFF_F000 : 32'(tv) << 8;
        return t | (32'($urandom_range(0, 15)) << 4)
                 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] exp_addrs [4];
        int c;
        int base;

        rst = 1'b1; req_valid = 1'b0; addr_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // cold miss
        base = ack_log.size();
        fetch(32'h40, d, c);
        check("cold_data", d, 32'hC0DE_0040);
        check("cold_stall_cycles", 32'(c >= 6), 32'd1);
        check("cold_beats", 32'(ack_log.size() - base), 32'd4);
        exp_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
        for (int i = 0; i < 4; i++) check("cold_beat_addr", ack_log[base + i], exp_addrs[i]);

        // hits on consecutive cycles
        fetch(32'h44, d, c);
        check("hit44_data", d, 32'hC0DE_0044);
        check("hit44_stall", 32'(c), 32'd0);
        fetch(32'h48, d, c);
        check("hit48_data", d, 32'hC0DE_0048);
        check("hit48_stall", 32'(c), 32'd0);
`ifdef ICACHE_STATS_EN
        check("stats_hits", hit_count, 32'd3);
        check("stats_misses", miss_count, 32'd1);
`endif
        fetch(32'h4C, d, c);
        check("hit4c_data", d, 32'hC0DE_004C);
        check("hit4c_stall", 32'(c), 32'd0);

        // conflict on index 4
        base = ack_log.size();
        fetch(32'h440, d, c);
        check("conflict_data", d, 32'hC0DE_0440);
        check("conflict_refill_addr", ack_log[base], 32'h440);
        check("conflict_missed", 32'(c > 0), 32'd1);
        fetch(32'h40, d, c);
        check("evicted_missed", 32'(c > 0), 32'd1);
        check("evicted_data", d, 32'hC0DE_0040);

        // flush during beat 2 of a refill
        base = ack_log.size();
        req_valid = 1'b1; addr_i = 32'h80;
        wait_acks(base + 2);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        fetch(32'h80, d, c);
        check("flush_first_last_beat", ack_log[base + 3], 32'h8C);
        check("flush_refetch_addr", ack_log[base + 4], 32'h80);
        check("flush_total_beats", 32'(ack_log.size() - base), 32'd8);
        check("flush_data", d, 32'hC0DE_0080);
        fetch(32'h40, d, c);
        check("flush_old_line_missed", 32'(c > 0), 32'd1);

        // reset after beat 1
        base = ack_log.size();
        req_valid = 1'b1; addr_i = 32'hC0;
        wait_acks(base + 1);
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mid_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        base = ack_log.size();
        fetch(32'hC0, d, c);
        check("rst_refill_missed", 32'(c > 0), 32'd1);
        check("rst_refill_start", ack_log[base], 32'hC0);
        check("rst_refill_beats", 32'(ack_log.size() - base), 32'd4);
        check("rst_refill_data", d, 32'hC0DE_00C0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (i == 1500) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            if (stall_o && $urandom_range(0, 19) != 0) begin
                flush_i = ($urandom_range(0, 29) == 0);
            end else begin
                req_valid = ($urandom_range(0, 9) != 0);
                addr_i    = rand_addr();
                flush_i   = ($urandom_range(0, 29) == 0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        check("global_timeout", 32'd1, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage's program counter and a slower multi-cycle backing instruction memory.
- Hits return the word in the same cycle with no stall.
- Misses assert a stall to the fetch stage, refill one full line beat by beat over a req/ack handshake, then resume.
- Replaces the fixed-latency instruction memory feeding the IF/ID instruction latch.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, instruction word width.
- LINES, 16, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, words per line (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch stage presents a valid address.
- addr_i  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- flush_i  in  1  invalidate all lines.
- data_o  out  DATA_WIDTH  instruction word; valid when req_valid=1 and stall_o=0.
- stall_o  out  1  fetch must hold PC and addr_i.
- mem_req  out  1  refill request to backing memory.
- mem_addr  out  ADDR_WIDTH  word-aligned refill beat address.
- mem_ack  in  1  beat accepted; mem_data valid this cycle.
- mem_data  in  DATA_WIDTH  refill beat data.

Behaviour:
- Address split: word offset = addr[2 +: log2(WORDS_PER_LINE)]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: per line a valid bit, a tag and WORDS_PER_LINE data words, all in registers.
- Lookup is combinational on addr_i.
- hit = req_valid & valid[index] & (tag match) & (state==IDLE).
- FSM states: IDLE, REFILL, FILL_DONE.
- IDLE:
  - Hit: stall_o=0, data_o = stored word, zero added latency.
  - req_valid & miss: stall_o=1 combinationally. Next edge captures the line base address (offset zeroed), clears beat counter, goes to REFILL.
  - req_valid=0: stall_o=0 and data_o is don't-care; drive 0.
- REFILL:
  - mem_req=1, mem_addr = line base + 4*beat, stall_o=1.
  - On mem_ack: write mem_data into data[index][beat] and increment beat.
  - On the ack for beat WORDS_PER_LINE-1: set tag, set valid, go to FILL_DONE.
  - Beats are strictly in order from offset 0; no critical-word-first.
  - mem_ack may arrive any number of cycles after the request, and never in the same cycle the REFILL state is entered from IDLE.
- FILL_DONE: mem_req=0, stall_o=1 for one cycle, then IDLE. The next cycle re-looks-up addr_i and hits.
- The fetch stage must hold addr_i stable while stall_o=1. If it changes anyway, the refill still completes to the captured line, and the IDLE re-lookup uses the new addr_i (may miss again).
- mem_ack while mem_req=0 is ignored.
- flush_i:
  - In IDLE: all valid bits clear at the next edge. A lookup in the same cycle is treated as a miss.
  - In REFILL/FILL_DONE: a pending_flush flag is set. The refill runs to completion so in-flight beats are honoured. On entering IDLE all valid bits clear, including the just-filled line.
- Reset (async): state IDLE, all valid=0, beat=0, pending_flush=0, mem_req=0, mem_addr=0, stall_o=0, data_o=0.
- Reset during REFILL: abort immediately with mem_req=0. The partially filled line stays invalid.
- Conflict: a new tag on an occupied index overwrites the line; no write-back (read-only).

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined: adds outputs hit_count and miss_count, each 32 bits, saturating. Both reset to 0 on rst.
  - hit_count increments on each cycle with hit=1.
  - miss_count increments once per IDLE->REFILL transition.
- When undefined: the ports and counters are absent and the rest of the behaviour is unchanged.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE=2'd0, REFILL=2'd1, FILL_DONE=2'd2).
  - Derived widths: OFFSET_BITS, INDEX_BITS, TAG_BITS.
  - Instruction width constant shared with the pipeline.
- One natural sub-module, icache_line_store: valid/tag/data arrays, combinational read, single-word write port, flush-all input.

Test Plan:
- Cold miss: after reset, req addr 0x40. Expect stall_o=1 and mem_req with mem_addr 0x40,0x44,0x48,0x4C; acks given with 0-2 idle gaps. Then data_o = beat for 0x40 and stall_o=0 on the cycle after FILL_DONE. Total 4 beats.
- Hits: following the cold miss, addrs 0x44, 0x48, 0x4C on consecutive cycles. Expect stall_o=0 throughout, correct words, mem_req=0.
- Conflict: with LINES=16, fetch 0x40 then 0x440 (same index, different tag). Expect a second refill from 0x440. A subsequent 0x40 misses again.
- Flush mid-refill: assert flush_i during beat 2 of a refill. Expect the refill to complete (4 acks consumed). Then in IDLE all lines invalid, and the re-lookup of the same address misses.
- Reset mid-refill: assert rst after beat 1. Expect mem_req=0 and stall_o=0 immediately. After release, the same address misses and refills from offset 0.
- ICACHE_STATS_EN: 1 miss followed by 3 hits. Expect miss_count=1, hit_count=3.
